ex_operand_stage: RTL

ID/EX pipeline register and operand-delivery stage of the 5-stage MIPS datapath; sits directly upstream of the ALU and drives its `busA`, `busB`, `ALUop` and `s` inputs. Captures decoded operands and control from ID each cycle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards, inserting a bubble and stalling IF/ID.

---
 rtl/ex_operand_stage_pkg.sv | 61 ++++++
 rtl/ex_operand_stage_fwd_unit.sv | 29 ++
 rtl/ex_operand_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// ============================================================================
// Module      : ex_operand_stage_pkg
// Description : Shared control encodings for the EX operand stage: ALU
//               opcodes, forwarding select codes and forwarding helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_operand_stage_pkg;

    localparam int c_data_w = 32;
    localparam int c_reg_w  = 5;

    localparam logic [2:0] c_alu_add = 3'd0;
    localparam logic [2:0] c_alu_sub = 3'd1;
    localparam logic [2:0] c_alu_and = 3'd2;
    localparam logic [2:0] c_alu_or  = 3'd3;
    localparam logic [2:0] c_alu_xor = 3'd4;
    localparam logic [2:0] c_alu_sll = 3'd5;
    localparam logic [2:0] c_alu_srl = 3'd6;
    localparam logic [2:0] c_alu_slt = 3'd7;

    localparam logic [1:0] c_fwd_reg   = 2'd0;
    localparam logic [1:0] c_fwd_exmem = 2'd1;
    localparam logic [1:0] c_fwd_memwb = 2'd2;

    // EX/MEM is the younger result, so it takes precedence over MEM/WB.
    function automatic logic [1:0] fwd_select(
        input logic [c_reg_w-1:0] src,
        input logic               exmem_we,
        input logic [c_reg_w-1:0] exmem_rd,
        input logic               memwb_we,
        input logic [c_reg_w-1:0] memwb_rd
    );
        logic [1:0] sel;
        sel = c_fwd_reg;
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == src))
            sel = c_fwd_exmem;
        else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src))
            sel = c_fwd_memwb;
        return sel;
    endfunction

    function automatic logic [c_data_w-1:0] fwd_mux(
        input logic [1:0]          sel,
        input logic [c_data_w-1:0] reg_val,
        input logic [c_data_w-1:0] exmem_val,
        input logic [c_data_w-1:0] memwb_val
    );
        logic [c_data_w-1:0] val;
        case (sel)
            c_fwd_exmem: val = exmem_val;
            c_fwd_memwb: val = memwb_val;
            default:     val = reg_val;
        endcase
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_operand_stage_fwd_unit.sv
// ============================================================================
// Module      : fwd_unit
// Description : Combinational forwarding-select generation for ALU operands
//               A (rs) and B (rt) from the EX/MEM and MEM/WB write ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_unit
    import ex_operand_stage_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_exmem_we,
    input  logic [4:0] i_exmem_rd,
    input  logic       i_memwb_we,
    input  logic [4:0] i_memwb_rd,
    output logic [1:0] o_sel_a,
    output logic [1:0] o_sel_b
);

    always_comb begin
        o_sel_a = fwd_select(i_rs, i_exmem_we, i_exmem_rd, i_memwb_we, i_memwb_rd);
        o_sel_b = fwd_select(i_rt, i_exmem_we, i_exmem_rd, i_memwb_we, i_memwb_rd);
    end

endmodule

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ============================================================================
// Module      : ex_operand_stage
// Description : ID/EX pipeline register with operand forwarding and load-use
//               hazard stall. Define FWD_EN to enable forwarding; otherwise
//               any pending write to a source register stalls ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_operand_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        hold,
    input  logic        id_valid,
    input  logic [31:0] id_busA,
    input  logic [31:0] id_busB,
    input  logic [31:0] id_imm32,
    input  logic        id_ALUSrc,
    input  logic [2:0]  id_ALUop,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_MemtoReg,
    input  logic        exmem_RegWrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_ALUout,
    input  logic        memwb_RegWrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_wdata,
    output logic        stall,
    output logic [31:0] busA,
    output logic [31:0] busB,
    output logic [2:0]  ALUop,
    output logic [4:0]  s,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_MemtoReg,
    output logic [31:0] ex_storedata
);

    import ex_operand_stage_pkg::*;

    logic        r_valid, r_alusrc, r_regwrite, r_memread, r_memwrite, r_memtoreg;
    logic [31:0] r_busA, r_busB, r_imm32;
    logic [2:0]  r_aluop;
    logic [4:0]  r_shamt, r_rs, r_rt, r_rd;

    logic [1:0]  w_sel_a, w_sel_b;
    logic [31:0] w_fwd_a, w_fwd_b;
    logic        w_hazard;

    fwd_unit u_fwd_unit (
        .i_rs       (r_rs),
        .i_rt       (r_rt),
        .i_exmem_we (exmem_RegWrite),
        .i_exmem_rd (exmem_rd),
        .i_memwb_we (memwb_RegWrite),
        .i_memwb_rd (memwb_rd),
        .o_sel_a    (w_sel_a),
        .o_sel_b    (w_sel_b)
    );

`ifdef FWD_EN
    assign w_fwd_a = fwd_mux(w_sel_a, r_busA, exmem_ALUout, memwb_wdata);
    assign w_fwd_b = fwd_mux(w_sel_b, r_busB, exmem_ALUout, memwb_wdata);

    // Only a load in EX cannot be covered by forwarding.
    assign w_hazard = r_valid && r_memread && (r_rd != 5'd0) && id_valid &&
                      ((r_rd == id_rs) || (r_rd == id_rt));
`else
    logic w_unused_fwd;
    logic w_ex_hit, w_mem_hit;

    assign w_fwd_a      = r_busA;
    assign w_fwd_b      = r_busB;
    assign w_unused_fwd = ^{w_sel_a, w_sel_b, exmem_ALUout, memwb_wdata};

    // Without forwarding, wait until the producer has left EX/MEM.
    assign w_ex_hit  = r_valid && r_regwrite &&
                       (((id_rs != 5'd0) && (id_rs == r_rd)) ||
                        ((id_rt != 5'd0) && (id_rt == r_rd)));
    assign w_mem_hit = exmem_RegWrite &&
                       (((id_rs != 5'd0) && (id_rs == exmem_rd)) ||
                        ((id_rt != 5'd0) && (id_rt == exmem_rd)));
    assign w_hazard  = id_valid && (w_ex_hit || w_mem_hit);
`endif

    assign stall        = w_hazard && !flush && !hold;
    assign busA         = w_fwd_a;
    assign busB         = r_alusrc ? r_imm32 : w_fwd_b;
    assign ex_storedata = w_fwd_b;
    assign ALUop        = r_aluop;
    assign s            = r_shamt;
    assign ex_valid     = r_valid;
    assign ex_rd        = r_rd;
    assign ex_RegWrite  = r_regwrite;
    assign ex_MemRead   = r_memread;
    assign ex_MemWrite  = r_memwrite;
    assign ex_MemtoReg  = r_memtoreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_busA     <= '0;
            r_busB     <= '0;
            r_imm32    <= '0;
            r_aluop    <= '0;
            r_shamt    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
        end else if (flush || (!hold && w_hazard)) begin
            // Bubble: data fields are left as they were.
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end else if (!hold) begin
            r_valid    <= id_valid;
            r_regwrite <= id_RegWrite;
            r_memread  <= id_MemRead;
            r_memwrite <= id_MemWrite;
            r_memtoreg <= id_MemtoReg;
            r_alusrc   <= id_ALUSrc;
            r_busA     <= id_busA;
            r_busB     <= id_busB;
            r_imm32    <= id_imm32;
            r_aluop    <= id_ALUop;
            r_shamt    <= id_shamt;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rd       <= id_rd;
        end
    end

endmodule

`default_nettype wire
